// File: rtl/sprite_dispatch_sched.sv
// Pops sprite draw-queue entries onto two renderers and arbitrates their shared sprite-memory read port.
// Optional statistics outputs are enabled by defining SPRITE_DISPATCH_STATS_EN.
module sprite_dispatch_sched #(
    parameter int ADDR_W = 17,
    parameter int N_REND = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fb_resetting,
    input  logic              q_is_empty,
    input  logic [7:0]        q_id,
    input  logic [15:0]       q_x,
    input  logic [15:0]       q_y,
    input  logic [7:0]        q_scale,
    output logic              q_dequeue,
    output logic [1:0]        r_start,
    output logic [7:0]        r_id,
    output logic [15:0]       r_x,
    output logic [15:0]       r_y,
    output logic [7:0]        r_scale,
    input  logic [1:0]        r_done,
    input  logic [1:0]        m_req,
    input  logic [ADDR_W-1:0] m_addr0,
    input  logic [ADDR_W-1:0] m_addr1,
    output logic [1:0]        m_gnt,
    output logic [1:0]        m_rvalid,
    output logic [ADDR_W-1:0] sprite_r_addr,
    output logic              sprite_r_en,
    output logic              frame_idle
`ifdef SPRITE_DISPATCH_STATS_EN
    ,
    output logic [15:0]       stat_dispatched,
    output logic [15:0]       stat_conflicts
`endif
);

    typedef enum logic {ST_IDLE, ST_GAP} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        busy_reg, busy_next;
    logic [1:0]        start_reg, start_next;
    logic [1:0]        start_live;
    logic [1:0]        dispatch_sel;
    logic              dispatch;
    logic [7:0]        id_reg, scale_reg;
    logic [15:0]       x_reg, y_reg;
    logic              rr_reg;
    logic [1:0]        gnt;
    logic [1:0]        rvalid_reg;
    logic [ADDR_W-1:0] addr_reg, addr_sel;
    logic              frame_idle_reg;

    // Dispatch FSM: one pop in IDLE, then a GAP cycle so the queue head can advance.
    always_comb begin
        state_next   = state_reg;
        start_next   = 2'b00;
        dispatch_sel = busy_reg[0] ? 2'b10 : 2'b01;
        dispatch     = (state_reg == ST_IDLE) && !reset && !fb_resetting
                       && !q_is_empty && (busy_reg != 2'b11);
        case (state_reg)
            ST_IDLE: begin
                if (dispatch) begin
                    state_next = ST_GAP;
                    start_next = dispatch_sel;
                end
            end
            ST_GAP:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (fb_resetting) begin
            state_next = ST_IDLE;
            start_next = 2'b00;
        end
    end

    // A scheduled start is dropped if reset or a framebuffer clear arrives first.
    assign start_live = start_reg & {2{~(reset | fb_resetting)}};
    assign q_dequeue  = dispatch;
    assign r_start    = start_live;
    assign r_id       = id_reg;
    assign r_x        = x_reg;
    assign r_y        = y_reg;
    assign r_scale    = scale_reg;

    generate
        for (genvar gi = 0; gi < N_REND; gi++) begin : g_busy
            assign busy_next[gi] = fb_resetting   ? 1'b0 :
                                   start_live[gi] ? 1'b1 :
                                   r_done[gi]     ? 1'b0 : busy_reg[gi];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 2'b00;
            start_reg <= 2'b00;
            id_reg    <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            scale_reg <= '0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= busy_next;
            start_reg <= start_next;
            if (dispatch) begin
                id_reg    <= q_id;
                x_reg     <= q_x;
                y_reg     <= q_y;
                scale_reg <= q_scale;
            end
        end
    end

    // Round-robin pointer only matters, and only moves, when both renderers ask.
    always_comb begin
        gnt = 2'b00;
        case (m_req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_reg ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        if (reset) gnt = 2'b00;
        addr_sel = gnt[1] ? m_addr1 : (gnt[0] ? m_addr0 : addr_reg);
        if (reset) addr_sel = '0;
    end

    assign m_gnt         = gnt;
    assign sprite_r_addr = addr_sel;
    assign sprite_r_en   = (|m_req) && !reset;
    assign m_rvalid      = rvalid_reg & {2{~(reset | fb_resetting)}};
    assign frame_idle    = reset | frame_idle_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_reg         <= 1'b0;
            addr_reg       <= '0;
            rvalid_reg     <= 2'b00;
            frame_idle_reg <= 1'b1;
        end else begin
            if (m_req == 2'b11) rr_reg <= ~rr_reg;
            if (|gnt) addr_reg <= addr_sel;
            rvalid_reg     <= fb_resetting ? 2'b00 : gnt;
            frame_idle_reg <= q_is_empty && (busy_reg == 2'b00)
                              && (state_reg == ST_IDLE) && (start_reg == 2'b00);
        end
    end

`ifdef SPRITE_DISPATCH_STATS_EN
    logic        fb_prev_reg;
    logic [15:0] disp_cnt_reg, conf_cnt_reg;

    always_ff @(posedge clock) begin
        if (reset || (fb_resetting && !fb_prev_reg)) begin
            disp_cnt_reg <= '0;
            conf_cnt_reg <= '0;
        end else begin
            if ((|start_live) && (disp_cnt_reg != 16'hFFFF)) disp_cnt_reg <= disp_cnt_reg + 16'd1;
            if ((m_req == 2'b11) && (conf_cnt_reg != 16'hFFFF)) conf_cnt_reg <= conf_cnt_reg + 16'd1;
        end
        fb_prev_reg <= reset ? 1'b0 : fb_resetting;
    end

    assign stat_dispatched = disp_cnt_reg;
    assign stat_conflicts  = conf_cnt_reg;
`endif

endmodule

// File: tb/tb_sprite_dispatch_sched.sv
// Randomized bench for sprite_dispatch_sched against a cycle-indexed reference model.
// Stats outputs are also checked when SPRITE_DISPATCH_STATS_EN is defined.
module tb_sprite_dispatch_sched;

    localparam int ADDR_W = 17;
    localparam int NCYC   = 3000;

    logic              clk = 1'b0;
    logic              rst_i, fb_i, empty_i;
    logic [7:0]        q_id_i, q_scale_i;
    logic [15:0]       q_x_i, q_y_i;
    logic              deq_o;
    logic [1:0]        start_o;
    logic [7:0]        rid_o, rscale_o;
    logic [15:0]       rx_o, ry_o;
    logic [1:0]        done_i, req_i;
    logic [ADDR_W-1:0] a0_i, a1_i;
    logic [1:0]        gnt_o, rvalid_o;
    logic [ADDR_W-1:0] saddr_o;
    logic              sen_o, idle_o;
`ifdef SPRITE_DISPATCH_STATS_EN
    logic [15:0]       sdisp_o, sconf_o;
`endif

    always #5 clk = ~clk;

    sprite_dispatch_sched #(.ADDR_W(ADDR_W), .N_REND(2)) dut (
        .clock(clk), .reset(rst_i), .fb_resetting(fb_i), .q_is_empty(empty_i),
        .q_id(q_id_i), .q_x(q_x_i), .q_y(q_y_i), .q_scale(q_scale_i),
        .q_dequeue(deq_o), .r_start(start_o), .r_id(rid_o), .r_x(rx_o), .r_y(ry_o),
        .r_scale(rscale_o), .r_done(done_i), .m_req(req_i), .m_addr0(a0_i), .m_addr1(a1_i),
        .m_gnt(gnt_o), .m_rvalid(rvalid_o), .sprite_r_addr(saddr_o), .sprite_r_en(sen_o),
        .frame_idle(idle_o)
`ifdef SPRITE_DISPATCH_STATS_EN
        , .stat_dispatched(sdisp_o), .stat_conflicts(sconf_o)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  scale;
    } entry_t;

    entry_t q[$];

    // Reference state: dispatch times and per-renderer occupancy rather than FSM encoding.
    int              last_disp;
    int              pend;
    bit              busy [2];
    entry_t          fields;
    bit              rr;
    logic [ADDR_W-1:0] last_addr;
    logic [1:0]      prev_gnt;
    bit              idle_q;
    int              rem [2];
    int              fb_left;
    bit              fb_prev;
    int              cnt_disp, cnt_conf;

    initial begin
        entry_t      e;
        bit          in_gap, disp, rst_now;
        int          k, dur;
        logic [1:0]  e_start, g;
        logic [ADDR_W-1:0] e_addr;
        bit          prev_deq;

        rst_i = 1'b1; fb_i = 1'b0; empty_i = 1'b1; q_id_i = '0; q_x_i = '0; q_y_i = '0;
        q_scale_i = '0; done_i = '0; req_i = '0; a0_i = '0; a1_i = '0;
        last_disp = -10; pend = -1; busy[0] = 0; busy[1] = 0; fields = '0; rr = 0;
        last_addr = '0; prev_gnt = '0; idle_q = 1; rem[0] = 0; rem[1] = 0; fb_left = 0;
        fb_prev = 0; cnt_disp = 0; cnt_conf = 0; prev_deq = 0;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            // Stimulus for this cycle
            rst_now = (c < 3) || (c >= 60 && $urandom_range(0, 299) == 0)
                      || (c >= 60 && prev_deq && $urandom_range(0, 19) == 0);
            if (c == 3) begin
                q.push_back('{8'd5, 16'd100, 16'd200, 8'd1});
                q.push_back('{8'd6, 16'd101, 16'd201, 8'd2});
                q.push_back('{8'd7, 16'd102, 16'd202, 8'd3});
            end
            if (fb_left > 0) begin
                fb_i = 1'b1; fb_left--;
            end else if (c >= 60 && $urandom_range(0, 149) == 0) begin
                fb_i = 1'b1; fb_left = $urandom_range(0, 11);
            end else begin
                fb_i = 1'b0;
            end
            rst_i = rst_now;
            if (c >= 3 && c < 7) req_i = 2'b11;
            else if (c < 60) req_i = 2'b00;
            else req_i = 2'($urandom_range(0, 3));
            a0_i = ADDR_W'($urandom);
            a1_i = ADDR_W'($urandom);
            empty_i = (q.size() == 0);
            if (q.size() != 0) begin
                e = q[0];
                q_id_i = e.id; q_x_i = e.x; q_y_i = e.y; q_scale_i = e.scale;
            end else begin
                q_id_i = 8'($urandom); q_x_i = 16'($urandom);
                q_y_i = 16'($urandom); q_scale_i = 8'($urandom);
            end
            for (int r = 0; r < 2; r++) done_i[r] = (rem[r] == 1);
            #1;

            // Expected outputs
            in_gap  = (c == last_disp + 1);
            disp    = !rst_i && !fb_i && !empty_i && !in_gap && !(busy[0] && busy[1]);
            k       = busy[0] ? 1 : 0;
            e_start = (!rst_i && !fb_i && pend >= 0) ? 2'(1 << pend) : 2'b00;
            case (req_i)
                2'b01:   g = 2'b01;
                2'b10:   g = 2'b10;
                2'b11:   g = rr ? 2'b10 : 2'b01;
                default: g = 2'b00;
            endcase
            if (rst_i) g = 2'b00;
            e_addr = rst_i ? '0 : (g[1] ? a1_i : (g[0] ? a0_i : last_addr));

            check_val("q_dequeue", 64'(deq_o), 64'(disp));
            check_val("r_start", 64'(start_o), 64'(e_start));
            check_val("m_gnt", 64'(gnt_o), 64'(g));
            check_val("m_rvalid", 64'(rvalid_o), 64'((rst_i || fb_i) ? 2'b00 : prev_gnt));
            check_val("sprite_r_addr", 64'(saddr_o), 64'(e_addr));
            check_val("sprite_r_en", 64'(sen_o), 64'(!rst_i && (req_i != 2'b00)));
            check_val("frame_idle", 64'(idle_o), 64'(rst_i || idle_q));
            if (!rst_i)
                check_val("r_fields", 64'({rid_o, rx_o, ry_o, rscale_o}), 64'(fields));
`ifdef SPRITE_DISPATCH_STATS_EN
            check_val("stat_dispatched", 64'(sdisp_o), 64'(cnt_disp));
            check_val("stat_conflicts", 64'(sconf_o), 64'(cnt_conf));
            if (rst_i || (fb_i && !fb_prev)) begin
                cnt_disp = 0; cnt_conf = 0;
            end else begin
                if (e_start != 2'b00 && cnt_disp < 16'hFFFF) cnt_disp++;
                if (req_i == 2'b11 && cnt_conf < 16'hFFFF) cnt_conf++;
            end
            fb_prev = rst_i ? 1'b0 : fb_i;
`endif
            if (disp)
                $display("cycle %0d: dispatch id=%0d to renderer %0d", c, q_id_i, k);

            // Advance reference model
            if (rst_i) begin
                busy[0] = 0; busy[1] = 0; pend = -1; last_disp = -10; fields = '0;
                rr = 0; last_addr = '0; prev_gnt = '0; idle_q = 1;
            end else begin
                idle_q = empty_i && !busy[0] && !busy[1] && !in_gap && pend < 0;
                for (int r = 0; r < 2; r++) begin
                    if (fb_i) busy[r] = 0;
                    else if (e_start[r]) busy[r] = 1;
                    else if (done_i[r]) busy[r] = 0;
                end
                pend = disp ? k : -1;
                if (disp) begin
                    fields = '{q_id_i, q_x_i, q_y_i, q_scale_i};
                    last_disp = c;
                end
                if (req_i == 2'b11) rr = !rr;
                if (g != 2'b00) last_addr = e_addr;
                prev_gnt = fb_i ? 2'b00 : g;
            end

            // Environment: queue pops/refills and renderer run times
            if (disp) void'(q.pop_front());
            if (c >= 60 && q.size() < 6 && $urandom_range(0, 2) == 0)
                q.push_back('{8'($urandom), 16'($urandom), 16'($urandom), 8'($urandom)});
            for (int r = 0; r < 2; r++) begin
                if (rst_i || fb_i) rem[r] = 0;
                else if (done_i[r]) rem[r] = 0;
                else if (rem[r] > 1) rem[r]--;
                if (e_start[r]) begin
                    dur = (c < 60) ? 17 : $urandom_range(2, 14);
                    rem[r] = dur;
                end
            end
            prev_deq = disp;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_dispatch_sched.md
Name: sprite_dispatch_sched

Overview:
- Sequences the two sprite_render engines from the sprite draw queue.
- Pops queue entries, assigns each to a free renderer, and arbitrates the single sprite-memory read port between both renderers.
- Sits between the draw queue / sprite ROM and renderers sr0/sr1 inside the sprite driver.
- Holds off all dispatch while the framebuffer is being cleared.

Parameters:
- ADDR_W, 17, sprite memory address width (SPRITE_ADDR_SIZE+1).
- N_REND, 2, number of renderers. Fixed at 2; other values unsupported.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- fb_resetting  in  1  framebuffer clear in progress; also resets renderers externally
- q_is_empty  in  1  queue empty; head fields valid whenever low (show-ahead)
- q_id  in  8  head sprite id
- q_x  in  16  head sprite x
- q_y  in  16  head sprite y
- q_scale  in  8  head sprite scale
- q_dequeue  out  1  one-cycle pop pulse
- r_start  out  2  per-renderer start pulse
- r_id  out  8  latched id, shared bus
- r_x  out  16  latched x, shared bus
- r_y  out  16  latched y, shared bus
- r_scale  out  8  latched scale, shared bus
- r_done  in  2  per-renderer one-cycle completion pulse
- m_req  in  2  per-renderer memory read request
- m_addr0  in  ADDR_W  renderer 0 read address
- m_addr1  in  ADDR_W  renderer 1 read address
- m_gnt  out  2  per-renderer grant, combinational
- m_rvalid  out  2  per-renderer read-data-valid
- sprite_r_addr  out  ADDR_W  sprite memory address
- sprite_r_en  out  1  sprite memory read enable
- frame_idle  out  1  queue empty, both renderers idle, no dispatch pending

Behaviour:
- Reset: all outputs 0 except frame_idle=1. Busy flags clear. RR pointer=0. FSM=IDLE.
- Busy tracking:
  - busy[k] set on the cycle r_start[k] pulses.
  - busy[k] cleared on r_done[k].
  - start and done in the same cycle for the same k: start wins, busy stays 1.
- Dispatch FSM, states IDLE and GAP:
  - IDLE: when !fb_resetting && !q_is_empty && some busy[k]==0, same cycle:
    - pulse q_dequeue;
    - register q_* into r_* (visible next cycle);
    - pulse r_start[k] next cycle, aligned with the r_* fields;
    - k = lowest-index free renderer;
    - go to GAP.
  - GAP: exactly 1 cycle, lets the queue head update, then back to IDLE.
  - Net rate: at most one dispatch per 2 cycles.
  - r_* hold their value until the next dispatch.
- fb_resetting high:
  - no dequeue;
  - busy[] cleared, since renderers are reset;
  - FSM forced to IDLE;
  - any r_start scheduled for the next cycle is suppressed and the popped entry is discarded.
- Memory arbiter:
  - Only one request: grant it.
  - Both request: grant renderer at RR pointer, then the pointer moves to the other renderer.
  - Pointer changes only on contention.
  - sprite_r_addr = granted address, combinational. sprite_r_en = |m_req.
  - m_rvalid[k] asserted exactly 1 cycle after m_gnt[k] (sync ROM latency 1).
  - m_rvalid forced 0 while fb_resetting or reset.
  - No request: sprite_r_addr holds its last value, m_gnt=0.
- frame_idle = q_is_empty && busy==0 && FSM==IDLE && no pending start. Registered, 1-cycle latency.
- Reset mid-dispatch: everything returns to reset values next cycle. No q_dequeue is issued in the reset cycle.

Optional Feature:
- Macro SPRITE_DISPATCH_STATS_EN.
- Defined adds two outputs:
  - stat_dispatched[15:0]: count of r_start pulses this frame, saturating at 0xFFFF.
  - stat_conflicts[15:0]: count of cycles with m_req==2'b11.
  - Both clear on reset and on the rising edge of fb_resetting.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Queue holds 3 entries (ids 5,6,7), renderers idle, no done:
  - q_dequeue at cycles t and t+2 only;
  - r_start=01 with r_id=5, then r_start=10 with r_id=6;
  - id 7 stays in queue.
- Continuing the above, pulse r_done[0] at cycle 20: renderer 0 restarts with r_id=7 within 2 cycles; frame_idle stays 0.
- m_req=11 for 4 cycles from reset:
  - m_gnt=01,10,01,10;
  - m_rvalid follows 1 cycle later;
  - sprite_r_addr alternates m_addr0 and m_addr1.
- fb_resetting high for 10 cycles with a non-empty queue and busy=11: no q_dequeue; busy clears; m_rvalid=0; dispatch resumes the cycle after deassert.
- Assert reset the cycle after a dispatch: no r_start; all outputs 0; frame_idle=1 next cycle when the queue is empty.
- STATS_EN, 3 dispatches plus 2 conflict cycles: stat_dispatched=3, stat_conflicts=2; both read 0 after the fb_resetting rising edge.
